cdb_arbiter: RTL and testbench

- Shares the SS common-data-bus broadcast slots among NREQ functional-unit result producers (ALU/CMP/MUL lanes). Reservation stations and the ROB consume the broadcast.
- Up to SS grants per cycle, chosen round-robin, with an age-based anti-starvation override.
- Registered outputs: a result granted in cycle N is broadcast in cycle N+1.

---
 rtl/cdb_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks up to SS functional-unit results per cycle
// (starved requesters first, then round-robin) and registers them onto the
// broadcast slots, one cycle after the grant.
module cdb_arbiter #(
    parameter int NREQ         = 4,
    parameter int SS           = 2,
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [DATA_W-1:0]        req_data  [NREQ],
    input  logic [TAG_W-1:0]         req_tag   [NREQ],
    output logic [NREQ-1:0]          req_ready,
    output logic [SS-1:0]            cdb_valid,
    output logic [DATA_W-1:0]        cdb_data  [SS],
    output logic [TAG_W-1:0]         cdb_tag   [SS],
    output logic [$clog2(NREQ)-1:0]  cdb_src   [SS]
);

    localparam int SRC_W = $clog2(NREQ);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NREQ - 1);

    // Round-robin pointer and per-requester wait counters
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AGE_W-1:0]   age_q [NREQ];
    logic [AGE_W-1:0]   age_d [NREQ];

    // Broadcast slot registers
    logic [SS-1:0]      cdb_valid_q;
    logic [DATA_W-1:0]  cdb_data_q [SS];
    logic [TAG_W-1:0]   cdb_tag_q  [SS];
    logic [SRC_W-1:0]   cdb_src_q  [SS];

    // Grant-selection results
    logic [NREQ-1:0]    starved;
    logic [NREQ-1:0]    st_grant;
    logic [NREQ-1:0]    rr_cand;
    logic [NREQ-1:0]    rr_rot;
    logic [NREQ-1:0]    rr_grant;
    logic [NREQ-1:0]    grant;
    logic [2*NREQ-1:0]  cand_wide;
    logic [2*NREQ-1:0]  grant_wide;
    logic [SS-1:0]      slot_vld;
    logic [SRC_W-1:0]   slot_src [SS];
    logic               rr_hit;
    logic [SRC_W-1:0]   rr_last;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_starved
            assign starved[gi] = req_valid[gi] && (age_q[gi] >= AGE_MAX);
        end
    endgenerate

    // Slot filling: starved requesters (lowest index first), then a
    // round-robin scan starting at rr_ptr. The scan runs on a copy of the
    // candidate vector rotated so that bit k is requester (rr_ptr+k) mod NREQ.
    always_comb begin
        int n;
        int idx;
        n          = 0;
        idx        = 0;
        st_grant   = '0;
        rr_cand    = '0;
        rr_rot     = '0;
        rr_grant   = '0;
        cand_wide  = '0;
        grant_wide = '0;
        slot_vld   = '0;
        rr_hit     = 1'b0;
        rr_last    = '0;
        for (int k = 0; k < SS; k++) begin
            slot_src[k] = '0;
        end
        if (!rst && !flush) begin
            for (int i = 0; i < NREQ; i++) begin
                if (starved[i] && n < SS) begin
                    for (int k = 0; k < SS; k++) begin
                        if (n == k) begin
                            slot_vld[k] = 1'b1;
                            slot_src[k] = SRC_W'(i);
                        end
                    end
                    st_grant[i] = 1'b1;
                    n = n + 1;
                end
            end
            rr_cand   = req_valid & ~st_grant;
            cand_wide = {rr_cand, rr_cand} >> rr_ptr_q;
            for (int k = 0; k < NREQ; k++) begin
                if (cand_wide[k] && n < SS) begin
                    idx = int'(rr_ptr_q) + k;
                    if (idx >= NREQ) begin
                        idx = idx - NREQ;
                    end
                    for (int s = 0; s < SS; s++) begin
                        if (n == s) begin
                            slot_vld[s] = 1'b1;
                            slot_src[s] = SRC_W'(idx);
                        end
                    end
                    rr_rot[k] = 1'b1;
                    rr_hit    = 1'b1;
                    rr_last   = SRC_W'(idx);
                    n = n + 1;
                end
            end
            // Undo the rotation to get grants in requester order
            grant_wide = {rr_rot, rr_rot} << rr_ptr_q;
            rr_grant   = grant_wide[2*NREQ-1:NREQ];
        end
        grant = st_grant | rr_grant;
    end

    assign req_ready = grant;

    // Pointer moves just past the last round-robin winner; starved-only
    // cycles leave it alone so the normal rotation is not disturbed.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rr_hit) begin
            rr_ptr_d = (rr_last == LAST_IDX) ? '0 : rr_last + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_age
            // Wait counter: cleared on grant, idle or flush; otherwise saturating count
            always_comb begin
                age_d[gi] = age_q[gi];
                if (flush || grant[gi] || !req_valid[gi]) begin
                    age_d[gi] = '0;
                end else if (age_q[gi] < AGE_MAX) begin
                    age_d[gi] = age_q[gi] + 1'b1;
                end
            end

            // Age register
            always_ff @(posedge clk) begin
                if (rst) begin
                    age_q[gi] <= '0;
                end else begin
                    age_q[gi] <= age_d[gi];
                end
            end
        end
    endgenerate

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < SS; gi++) begin : g_slot
            // Broadcast slot: payload only reloads when the slot is used
            always_ff @(posedge clk) begin
                if (rst) begin
                    cdb_valid_q[gi] <= 1'b0;
                    cdb_data_q[gi]  <= '0;
                    cdb_tag_q[gi]   <= '0;
                    cdb_src_q[gi]   <= '0;
                end else begin
                    cdb_valid_q[gi] <= slot_vld[gi];
                    if (slot_vld[gi]) begin
                        cdb_data_q[gi] <= req_data[slot_src[gi]];
                        cdb_tag_q[gi]  <= req_tag[slot_src[gi]];
                        cdb_src_q[gi]  <= slot_src[gi];
                    end
                end
            end

            assign cdb_data[gi] = cdb_data_q[gi];
            assign cdb_tag[gi]  = cdb_tag_q[gi];
            assign cdb_src[gi]  = cdb_src_q[gi];
        end
    endgenerate

    assign cdb_valid = cdb_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a 4-requester instance for round-robin,
// wrap, flush and reset behaviour, and a 6-requester instance where the
// starvation override can actually engage.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int N6 = 6;
    localparam int SS = 2;

    typedef struct {
        logic [1:0]  v;
        logic [2:0]  s0, s1;
        logic [31:0] d0, d1;
        logic [7:0]  t0, t1;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush;
    logic [N-1:0] req_valid, req_ready;
    logic [31:0] req_data [N];
    logic [7:0]  req_tag  [N];
    logic [SS-1:0] cdb_valid;
    logic [31:0] cdb_data [SS];
    logic [7:0]  cdb_tag  [SS];
    logic [1:0]  cdb_src  [SS];

    logic [N6-1:0] s_valid, s_ready;
    logic [31:0] s_data [N6];
    logic [7:0]  s_tag  [N6];
    logic [SS-1:0] s_cdb_valid;
    logic [31:0] s_cdb_data [SS];
    logic [7:0]  s_cdb_tag  [SS];
    logic [2:0]  s_cdb_src  [SS];

    exp_t q_main[$];
    exp_t q_s[$];
    int errors = 0;
    int checks = 0;

    cdb_arbiter #(.NREQ(N), .SS(SS), .DATA_W(32), .TAG_W(8), .STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_data(req_data), .req_tag(req_tag),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
        .cdb_tag(cdb_tag), .cdb_src(cdb_src)
    );

    cdb_arbiter #(.NREQ(N6), .SS(SS), .DATA_W(32), .TAG_W(8), .STARVE_LIMIT(2)) dut_s (
        .clk(clk), .rst(rst), .flush(1'b0),
        .req_valid(s_valid), .req_data(s_data), .req_tag(s_tag),
        .req_ready(s_ready), .cdb_valid(s_cdb_valid), .cdb_data(s_cdb_data),
        .cdb_tag(s_cdb_tag), .cdb_src(s_cdb_src)
    );

    // Monitor for the 4-requester instance
    always @(negedge clk) begin
        if (cdb_valid != '0) begin
            exp_t e;
            checks++;
            if (q_main.size() == 0) begin
                errors++;
                $display("FAIL cdb_main_unexpected got valid=%b required no broadcast", cdb_valid);
            end else begin
                e = q_main.pop_front();
                if (cdb_valid !== e.v
                    || {1'b0, cdb_src[0]} !== e.s0 || cdb_data[0] !== e.d0 || cdb_tag[0] !== e.t0
                    || (e.v[1] && ({1'b0, cdb_src[1]} !== e.s1 || cdb_data[1] !== e.d1 || cdb_tag[1] !== e.t1))) begin
                    errors++;
                    $display("FAIL cdb_main got v=%b src=%0d/%0d tag=%0d/%0d data=%h/%h required v=%b src=%0d/%0d tag=%0d/%0d data=%h/%h",
                             cdb_valid, cdb_src[0], cdb_src[1], cdb_tag[0], cdb_tag[1], cdb_data[0], cdb_data[1],
                             e.v, e.s0, e.s1, e.t0, e.t1, e.d0, e.d1);
                end
            end
        end
    end

    // Monitor for the 6-requester instance
    always @(negedge clk) begin
        if (s_cdb_valid != '0) begin
            exp_t e;
            checks++;
            if (q_s.size() == 0) begin
                errors++;
                $display("FAIL cdb_starve_unexpected got valid=%b required no broadcast", s_cdb_valid);
            end else begin
                e = q_s.pop_front();
                if (s_cdb_valid !== e.v
                    || s_cdb_src[0] !== e.s0 || s_cdb_data[0] !== e.d0 || s_cdb_tag[0] !== e.t0
                    || (e.v[1] && (s_cdb_src[1] !== e.s1 || s_cdb_data[1] !== e.d1 || s_cdb_tag[1] !== e.t1))) begin
                    errors++;
                    $display("FAIL cdb_starve got v=%b src=%0d/%0d tag=%0d/%0d required v=%b src=%0d/%0d tag=%0d/%0d",
                             s_cdb_valid, s_cdb_src[0], s_cdb_src[1], s_cdb_tag[0], s_cdb_tag[1],
                             e.v, e.s0, e.s1, e.t0, e.t1);
                end
            end
        end
    end

    // One cycle on the 4-requester instance; e0/e1 are expected slot owners (-1 = empty)
    task automatic step(input logic [N-1:0] v, input logic fl, input logic rs,
                        input logic [N-1:0] exp_rdy, input int e0, input int e1);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        flush     = fl;
        rst       = rs;
        @(negedge clk);
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready got %b required %b (valid=%b flush=%b rst=%b)", req_ready, exp_rdy, v, fl, rs);
        end
        $display("main: valid=%b flush=%b rst=%b ready=%b slots=%0d/%0d", v, fl, rs, req_ready, e0, e1);
        if (e0 >= 0) begin
            e.v  = {(e1 >= 0), 1'b1};
            e.s0 = 3'(e0);
            e.d0 = req_data[e0];
            e.t0 = req_tag[e0];
            e.s1 = (e1 >= 0) ? 3'(e1) : 3'd0;
            e.d1 = (e1 >= 0) ? req_data[e1] : 32'd0;
            e.t1 = (e1 >= 0) ? req_tag[e1] : 8'd0;
            q_main.push_back(e);
        end
    endtask

    // One cycle on the 6-requester instance
    task automatic step_s(input logic [N6-1:0] v, input logic [N6-1:0] exp_rdy,
                          input int e0, input int e1);
        exp_t e;
        @(posedge clk);
        #1;
        s_valid = v;
        @(negedge clk);
        checks++;
        if (s_ready !== exp_rdy) begin
            errors++;
            $display("FAIL starve_ready got %b required %b", s_ready, exp_rdy);
        end
        $display("starve: valid=%b ready=%b slots=%0d/%0d", v, s_ready, e0, e1);
        if (e0 >= 0) begin
            e.v  = {(e1 >= 0), 1'b1};
            e.s0 = 3'(e0);
            e.d0 = s_data[e0];
            e.t0 = s_tag[e0];
            e.s1 = (e1 >= 0) ? 3'(e1) : 3'd0;
            e.d1 = (e1 >= 0) ? s_data[e1] : 32'd0;
            e.t1 = (e1 >= 0) ? s_tag[e1] : 8'd0;
            q_s.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        s_valid   = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i] = 32'h0000_0100 + 32'(i);
            req_tag[i]  = 8'(10 + i);
        end
        for (int i = 0; i < N6; i++) begin
            s_data[i] = 32'h0000_0200 + 32'(i);
            s_tag[i]  = 8'(20 + i);
        end

        // Reset, including valid requests while reset is high
        step(4'b0000, 1'b0, 1'b1, 4'b0000, -1, -1);
        step(4'b1111, 1'b0, 1'b1, 4'b0000, -1, -1);
        repeat (5) step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1);

        // All four valid: {0,1}, {2,3}, {0,1}
        step(4'b1111, 1'b0, 1'b0, 4'b0011, 0, 1);
        step(4'b1111, 1'b0, 1'b0, 4'b1100, 2, 3);
        step(4'b1111, 1'b0, 1'b0, 4'b0011, 0, 1);

        // Lone requester 3; pointer then wraps to 0
        req_data[3] = 32'hDEAD_BEEF;
        req_tag[3]  = 8'd5;
        step(4'b1000, 1'b0, 1'b0, 4'b1000, 3, -1);
        step(4'b1111, 1'b0, 1'b0, 4'b0011, 0, 1);

        // Fewer valid than slots (pointer at 2): scan order 2 then 0
        step(4'b0101, 1'b0, 1'b0, 4'b0101, 2, 0);

        // Flush: no grants, pointer stays at 1
        step(4'b1111, 1'b1, 1'b0, 4'b0000, -1, -1);
        step(4'b1111, 1'b0, 1'b0, 4'b0110, 1, 2);
        step(4'b1111, 1'b0, 1'b0, 4'b1001, 3, 0);

        // Reset mid-stream with both slots busy; pointer returns to 0
        step(4'b1111, 1'b0, 1'b1, 4'b0000, -1, -1);
        step(4'b1111, 1'b0, 1'b0, 4'b0011, 0, 1);

        // Reset and flush together: reset wins
        step(4'b1111, 1'b1, 1'b1, 4'b0000, -1, -1);
        step(4'b1111, 1'b0, 1'b0, 4'b0011, 0, 1);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, -1, -1);

        // Starvation override on six requesters, all held valid
        step_s(6'b111111, 6'b000011, 0, 1);
        step_s(6'b111111, 6'b001100, 2, 3);
        step_s(6'b111111, 6'b110000, 4, 5);
        step_s(6'b111111, 6'b000011, 0, 1);
        step_s(6'b111111, 6'b001100, 2, 3);
        step_s(6'b000000, 6'b000000, -1, -1);
        step_s(6'b000000, 6'b000000, -1, -1);

        @(negedge clk);
        checks++;
        if (q_main.size() != 0 || q_s.size() != 0) begin
            errors++;
            $display("FAIL missing_broadcasts got %0d/%0d outstanding required 0/0", q_main.size(), q_s.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
